sample_packetizer: RTL
======================

SAMPLE_PACKETIZER -- requirements
Module: sample_packetizer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sample and output byte width.
REQ-002 Parameter FRAME_LEN, default 16, payload samples per frame (2..FIFO_DEPTH).
REQ-003 Parameter FIFO_DEPTH, default 32, sample buffer entries (power of two).
REQ-004 Parameter SYNC_BYTE, default 8'hA5, frame header byte.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 valid_in  input  1  one-cycle strobe, data_in valid (driven by decimator valid output).
REQ-008 data_in  input  DATA_WIDTH signed  decimated filter sample.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_valid  output  1  out_data holds a valid byte.
REQ-011 out_data  output  DATA_WIDTH  frame byte.
REQ-012 out_last  output  1  high with the final byte (checksum) of a frame.
REQ-013 drop_count  output  8  saturating count of samples lost to overflow.

Function
REQ-014 Samples SHALL be buffered in a FIFO_DEPTH-entry FIFO with occupancy count; payload bytes are the raw two's-complement bit pattern of data_in.
REQ-015 A push SHALL occur when valid_in=1 and (count<FIFO_DEPTH, or a pop occurs the same cycle).
REQ-016 valid_in=1 with the FIFO full and no same-cycle pop SHALL discard the sample and increment drop_count, saturating at 255.
REQ-017 A pop SHALL occur only on a PAYLOAD byte handshake (out_valid & out_ready).
REQ-018 FSM states: IDLE, HDR, SEQ, PAY, CHK.
REQ-019 IDLE -> HDR when registered count>=FRAME_LEN; out_valid rises the cycle after the edge at which count reaches FRAME_LEN, carrying SYNC_BYTE.
REQ-020 HDR -> SEQ on handshake; SEQ emits the 8-bit frame sequence number.
REQ-021 SEQ -> PAY on handshake; PAY emits FRAME_LEN FIFO samples in arrival order, using a payload counter 0..FRAME_LEN-1.
REQ-022 PAY -> CHK on the handshake of payload byte FRAME_LEN-1; CHK emits the XOR of all FRAME_LEN payload bytes with out_last=1.
REQ-023 CHK handshake: sequence number increments (wraps 255->0); next state HDR if count>=FRAME_LEN at that edge, else IDLE; no idle bubble between back-to-back frames.
REQ-024 out_valid, out_data and out_last SHALL be registered and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 out_valid SHALL be 0 in IDLE; outside CHK, out_last SHALL be 0.
REQ-026 Full throughput: with out_ready held 1, one byte per cycle; a frame occupies exactly FRAME_LEN+3 cycles.
REQ-027 Input SHALL continue to be accepted during all states, including stalls; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-028 Checksum accumulator SHALL clear on entry to HDR.

Reset
REQ-029 rst=1 SHALL immediately clear FIFO pointers and count, state=IDLE, seq=0, checksum=0, drop_count=0, out_valid=0, out_data=0, out_last=0.
REQ-030 Reset mid-frame SHALL abandon the frame; buffered samples are lost; the first frame after reset carries seq=0.
REQ-031 No valid_in sample SHALL be accepted while rst=1.

Verification
REQ-032 Push 16 samples 1..16 with out_ready=1 -> bytes A5,00,01..10 (hex), then checksum 10 with out_last=1; out_valid high one cycle after 16th push.
REQ-033 Push 32 samples, out_ready=1 -> two back-to-back frames, seq 00 then 01, 38 contiguous valid cycles, drop_count=0.
REQ-034 Hold out_ready=0, push 40 samples -> drop_count=8, count=32; release -> two complete frames of samples 1..32.
REQ-035 Toggle out_ready 1/0 each cycle during a frame -> each byte held stable while stalled; sequence identical to REQ-032.
REQ-036 Assert rst during PAY byte 5 -> outputs zero immediately; next 16 pushes produce frame with seq=00.
REQ-037 Push samples 80..8F (negative values) -> payload bytes 80..8F unchanged, checksum 00.

Source files
------------

// File: rtl/sample_packetizer_if.sv
// rtl/sample_packetizer_if.sv - sample input and framed byte output bundle for sample_packetizer
interface sample_packetizer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                         valid_in;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         out_ready;
    logic                         out_valid;
    logic        [DATA_WIDTH-1:0] out_data;
    logic                         out_last;
    logic        [7:0]            drop_count;

    // packetizer side
    modport master (
        input  valid_in,
        input  data_in,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last,
        output drop_count
    );

    // sample source / byte sink side
    modport slave (
        output valid_in,
        output data_in,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  drop_count
    );
endinterface

// File: rtl/sample_packetizer.sv
// rtl/sample_packetizer.sv - buffers samples and emits sync/seq/payload/xor-checksum byte frames
module sample_packetizer #(
    parameter int          DATA_WIDTH = 8,
    parameter int          FRAME_LEN  = 16,
    parameter int          FIFO_DEPTH = 32,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    sample_packetizer_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FRAME_C    = CW'(FRAME_LEN);
    localparam logic [PW-1:0] PAY_LAST_C = PW'(FRAME_LEN - 1);

    typedef enum logic [2:0] {IDLE, HDR, SEQ, PAY, CHK} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         pay_cnt_q, pay_cnt_d;
    logic [7:0]            seq_q, seq_d, drop_q, drop_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d, out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                  hs, push, pop;

    assign hs      = out_valid_q & bus.out_ready;
    assign rd_next = rd_ptr_q + AW'(1);

    // Frame sequencing: the output register is loaded with the byte for the state being entered
    always_comb begin
        state_d     = state_q;
        pay_cnt_d   = pay_cnt_q;
        seq_d       = seq_q;
        chk_d       = chk_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q >= FRAME_C) begin
                    state_d     = HDR;
                    out_valid_d = 1'b1;
                    out_data_d  = DATA_WIDTH'(SYNC_BYTE);
                    chk_d       = '0;
                end
            end
            HDR: begin
                if (hs) begin
                    state_d    = SEQ;
                    out_data_d = DATA_WIDTH'(seq_q);
                end
            end
            SEQ: begin
                if (hs) begin
                    state_d    = PAY;
                    pay_cnt_d  = '0;
                    out_data_d = mem[rd_ptr_q];
                end
            end
            PAY: begin
                if (hs) begin
                    pop   = 1'b1;
                    chk_d = chk_q ^ out_data_q;
                    if (pay_cnt_q == PAY_LAST_C) begin
                        state_d    = CHK;
                        out_data_d = chk_q ^ out_data_q;
                        out_last_d = 1'b1;
                    end else begin
                        pay_cnt_d  = pay_cnt_q + PW'(1);
                        out_data_d = mem[rd_next];
                    end
                end
            end
            CHK: begin
                if (hs) begin
                    seq_d      = seq_q + 8'd1;
                    out_last_d = 1'b0;
                    if (count_q >= FRAME_C) begin
                        state_d    = HDR;
                        out_data_d = DATA_WIDTH'(SYNC_BYTE);
                        chk_d      = '0;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping: a pop frees a slot for a same-cycle push when full
    always_comb begin
        push     = bus.valid_in & ((count_q < DEPTH_C) | pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_next           : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
        drop_d = drop_q;
        if (bus.valid_in && !push && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    // Sample storage, no reset needed since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.data_in;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pay_cnt_q   <= '0;
            seq_q       <= '0;
            chk_q       <= '0;
            drop_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pay_cnt_q   <= pay_cnt_d;
            seq_q       <= seq_d;
            chk_q       <= chk_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.drop_count = drop_q;
endmodule
